decode_stage: RTL and testbench

//  Registered RV32I(M) decode stage between fetch and register-read/execute.

---
 rtl/rv_pkg.sv | 58 +++++
 rtl/decode_stage_if.sv | 38 +++
 rtl/dec_comb.sv | 129 ++++++++++++
 rtl/decode_stage.sv | 98 +++++++++
 tb/tb_decode_stage.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I(M) decode types: opcodes, immediate formats and the decoded bundle.
package rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
        logic [XLEN-1:0]   imm;
        fmt_t              fmt;
        logic              use_rs1;
        logic              use_rs2;
        logic              wr_rd;
        logic              is_mul;
        logic              illegal;
    } dec_bundle_t;

    // Empty bundle: every field zero, format NONE.
    function automatic dec_bundle_t bundle_rst();
        dec_bundle_t b;
        b     = '0;
        b.fmt = FMT_NONE;
        return b;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side handshake plus decoded-bundle outputs of the decode stage.
interface decode_stage_if;
    import rv_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     in_instr;
    logic [XLEN-1:0]     in_pc;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [ADDR_W-1:0]   rs1;
    logic [ADDR_W-1:0]   rs2;
    logic [ADDR_W-1:0]   rd;
    logic [XLEN-1:0]     imm;
    fmt_t                fmt;
    logic                use_rs1;
    logic                use_rs2;
    logic                wr_rd;
    logic                is_mul;
    logic                illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, funct3, funct7,
               rs1, rs2, rd, imm, fmt, use_rs1, use_rs2, wr_rd, is_mul, illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, funct3, funct7,
               rs1, rs2, rd, imm, fmt, use_rs1, use_rs2, wr_rd, is_mul, illegal
    );

endinterface

// File: rtl/dec_comb.sv
// Purely combinational instruction word -> decoded bundle.
module dec_comb
    import rv_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    output dec_bundle_t     dec
);

    logic [6:0]      op;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            sgn;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign op  = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];
    assign sgn = instr[31];

    assign imm_i = {{(XLEN-12){sgn}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){sgn}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){sgn}}, sgn, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){sgn}}, sgn, instr[19:12], instr[20], instr[30:21], 1'b0};

    // Format, immediate and register-usage selection; illegal encodings squash all usage.
    always_comb begin
        dec         = bundle_rst();
        dec.pc      = pc;
        dec.opcode  = op;
        dec.funct3  = f3;
        dec.funct7  = f7;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];

        case (op)
            OP_OP: begin
                dec.fmt     = FMT_R;
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.wr_rd   = 1'b1;
                case (f7)
                    F7_ZERO: dec.illegal = 1'b0;
                    F7_ALT:  dec.illegal = (f3 != 3'b000) && (f3 != 3'b101);
                    F7_MUL: begin
                        dec.illegal = !EN_M;
                        dec.is_mul  = EN_M;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec.fmt     = FMT_I;
                dec.imm     = imm_i;
                dec.use_rs1 = 1'b1;
                dec.wr_rd   = 1'b1;
                if (f3 == 3'b001) dec.illegal = (f7 != F7_ZERO);
                if (f3 == 3'b101) dec.illegal = (f7 != F7_ZERO) && (f7 != F7_ALT);
            end
            OP_LOAD: begin
                dec.fmt     = FMT_I;
                dec.imm     = imm_i;
                dec.use_rs1 = 1'b1;
                dec.wr_rd   = 1'b1;
                dec.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_JALR: begin
                dec.fmt     = FMT_I;
                dec.imm     = imm_i;
                dec.use_rs1 = 1'b1;
                dec.wr_rd   = 1'b1;
                dec.illegal = (f3 != 3'b000);
            end
            OP_SYSTEM: begin
                dec.fmt     = FMT_I;
                dec.imm     = imm_i;
                dec.use_rs1 = 1'b1;
                dec.wr_rd   = 1'b1;
            end
            OP_STORE: begin
                dec.fmt     = FMT_S;
                dec.imm     = imm_s;
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.illegal = (f3 >= 3'b011);
            end
            OP_BRANCH: begin
                dec.fmt     = FMT_B;
                dec.imm     = imm_b;
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LUI, OP_AUIPC: begin
                dec.fmt   = FMT_U;
                dec.imm   = imm_u;
                dec.wr_rd = 1'b1;
            end
            OP_JAL: begin
                dec.fmt   = FMT_J;
                dec.imm   = imm_j;
                dec.wr_rd = 1'b1;
            end
            OP_MISC_MEM: begin
                dec.fmt = FMT_I;
                dec.imm = imm_i;
            end
            default: dec.illegal = 1'b1;
        endcase

        if (instr[1:0] != 2'b11) dec.illegal = 1'b1;

        if (dec.illegal) begin
            dec.fmt     = FMT_NONE;
            dec.imm     = '0;
            dec.use_rs1 = 1'b0;
            dec.use_rs2 = 1'b0;
            dec.wr_rd   = 1'b0;
            dec.is_mul  = 1'b0;
        end

        if (dec.rd == '0) dec.wr_rd = 1'b0;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: main output register plus one skid entry behind valid/ready.
module decode_stage
    import rv_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic           clock,
    input  logic           n_reset,
    input  logic           flush,
    decode_stage_if.slave  bus
);

    dec_bundle_t dec_new;
    dec_bundle_t main_q, main_n;
    dec_bundle_t skid_q, skid_n;
    logic        main_v_q, main_v_n;
    logic        skid_v_q, skid_v_n;
    logic        in_ready_q, in_ready_n;
    logic        acc, drain;

    dec_comb #(.EN_M(EN_M)) u_dec (
        .instr (bus.in_instr),
        .pc    (bus.in_pc),
        .dec   (dec_new)
    );

    assign acc   = bus.in_valid && in_ready_q;
    assign drain = main_v_q && bus.out_ready;

    // Occupancy update: skid refills main on drain, new accepts go to main or skid.
    always_comb begin
        main_n   = main_q;
        skid_n   = skid_q;
        main_v_n = main_v_q;
        skid_v_n = skid_v_q;

        if (flush) begin
            main_n   = bundle_rst();
            skid_n   = bundle_rst();
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (drain) begin
            if (skid_v_q) begin
                main_n   = skid_q;
                skid_v_n = 1'b0;
            end else if (acc) begin
                main_n = dec_new;
            end else begin
                main_v_n = 1'b0;
            end
        end else if (acc) begin
            if (main_v_q) begin
                skid_n   = dec_new;
                skid_v_n = 1'b1;
            end else begin
                main_n   = dec_new;
                main_v_n = 1'b1;
            end
        end

        in_ready_n = !skid_v_n;
    end

    // State registers; reset empties both entries and clears the visible bundle.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            main_q     <= bundle_rst();
            skid_q     <= bundle_rst();
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            main_q     <= main_n;
            skid_q     <= skid_n;
            main_v_q   <= main_v_n;
            skid_v_q   <= skid_v_n;
            in_ready_q <= in_ready_n;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_v_q;
    assign bus.out_pc    = main_q.pc;
    assign bus.opcode    = main_q.opcode;
    assign bus.funct3    = main_q.funct3;
    assign bus.funct7    = main_q.funct7;
    assign bus.rs1       = main_q.rs1;
    assign bus.rs2       = main_q.rs2;
    assign bus.rd        = main_q.rd;
    assign bus.imm       = main_q.imm;
    assign bus.fmt       = main_q.fmt;
    assign bus.use_rs1   = main_q.use_rs1;
    assign bus.use_rs2   = main_q.use_rs2;
    assign bus.wr_rd     = main_q.wr_rd;
    assign bus.is_mul    = main_q.is_mul;
    assign bus.illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (EN_M=1 and EN_M=0 instances).
module tb_decode_stage;
    import rv_pkg::*;

    logic clock   = 1'b0;
    logic n_reset = 1'b0;
    logic flush   = 1'b0;
    int   checks  = 0;
    int   passes  = 0;

    decode_stage_if dif ();
    decode_stage_if dnm ();

    decode_stage #(.EN_M(1'b1)) u_dut (
        .clock   (clock),
        .n_reset (n_reset),
        .flush   (flush),
        .bus     (dif.slave)
    );

    decode_stage #(.EN_M(1'b0)) u_dut_nm (
        .clock   (clock),
        .n_reset (n_reset),
        .flush   (flush),
        .bus     (dnm.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic send_dut(input logic [31:0] instr, input logic [31:0] pc);
        @(negedge clock);
        dif.in_valid = 1'b1; dif.in_instr = instr; dif.in_pc = pc; dif.out_ready = 1'b1;
        @(negedge clock);
        dif.in_valid = 1'b0;
    endtask

    task automatic send_nm(input logic [31:0] instr, input logic [31:0] pc);
        @(negedge clock);
        dnm.in_valid = 1'b1; dnm.in_instr = instr; dnm.in_pc = pc; dnm.out_ready = 1'b1;
        @(negedge clock);
        dnm.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_reset = 1'b0; flush = 1'b0;
        dif.in_valid = 1'b0; dif.in_instr = '0; dif.in_pc = '0; dif.out_ready = 1'b0;
        dnm.in_valid = 1'b0; dnm.in_instr = '0; dnm.in_pc = '0; dnm.out_ready = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (dif.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", dif.out_valid); else passes++;
        checks++; if (dif.fmt !== FMT_NONE) $display("FAIL rst_fmt: got %0d expected %0d", dif.fmt, FMT_NONE); else passes++;
        checks++; if (dif.imm !== 32'h0 || dif.out_pc !== 32'h0) $display("FAIL rst_bundle: got imm %h pc %h expected 0", dif.imm, dif.out_pc); else passes++;
        n_reset = 1'b1;
        @(negedge clock);
        checks++; if (dif.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", dif.in_ready); else passes++;
        checks++; if (dif.out_valid !== 1'b0) $display("FAIL rst_release_valid: got %b expected 0", dif.out_valid); else passes++;
    endtask

    task automatic test_addi();
        send_dut(32'hFFF00093, 32'h100);
        checks++; if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'h100) $display("FAIL addi_valid_pc: got %b/%h expected 1/00000100", dif.out_valid, dif.out_pc); else passes++;
        checks++; if (dif.imm !== 32'hFFFFFFFF) $display("FAIL addi_imm: got %h expected ffffffff", dif.imm); else passes++;
        checks++; if (dif.fmt !== FMT_I) $display("FAIL addi_fmt: got %0d expected %0d", dif.fmt, FMT_I); else passes++;
        checks++; if (dif.rd !== 5'd1 || dif.wr_rd !== 1'b1 || dif.use_rs1 !== 1'b1 || dif.use_rs2 !== 1'b0)
            $display("FAIL addi_regs: got rd %0d wr %b r1 %b r2 %b expected 1 1 1 0", dif.rd, dif.wr_rd, dif.use_rs1, dif.use_rs2); else passes++;
        checks++; if (dif.illegal !== 1'b0) $display("FAIL addi_illegal: got %b expected 0", dif.illegal); else passes++;
    endtask

    task automatic test_imm_formats();
        send_dut(32'hFE20AE23, 32'h104);
        checks++; if (dif.imm !== 32'hFFFFFFFC) $display("FAIL sw_imm: got %h expected fffffffc", dif.imm); else passes++;
        checks++; if (dif.fmt !== FMT_S || dif.use_rs2 !== 1'b1 || dif.wr_rd !== 1'b0 || dif.rs1 !== 5'd1 || dif.rs2 !== 5'd2)
            $display("FAIL sw_fields: got fmt %0d r2 %b wr %b rs1 %0d rs2 %0d expected 2 1 0 1 2", dif.fmt, dif.use_rs2, dif.wr_rd, dif.rs1, dif.rs2); else passes++;
        send_dut(32'h80000063, 32'h108);
        checks++; if (dif.imm !== 32'hFFFFF000 || dif.fmt !== FMT_B) $display("FAIL beq_min_imm: got %h fmt %0d expected fffff000 3", dif.imm, dif.fmt); else passes++;
        send_dut(32'h800000E3, 32'h10C);
        checks++; if (dif.imm !== 32'hFFFFF800) $display("FAIL beq_2048_imm: got %h expected fffff800", dif.imm); else passes++;
        send_dut(32'h001000EF, 32'h110);
        checks++; if (dif.imm !== 32'h00000800 || dif.fmt !== FMT_J || dif.wr_rd !== 1'b1)
            $display("FAIL jal: got imm %h fmt %0d wr %b expected 00000800 5 1", dif.imm, dif.fmt, dif.wr_rd); else passes++;
        send_dut(32'h12345037, 32'h114);
        checks++; if (dif.imm !== 32'h12345000 || dif.fmt !== FMT_U || dif.wr_rd !== 1'b0)
            $display("FAIL lui_x0: got imm %h fmt %0d wr %b expected 12345000 4 0", dif.imm, dif.fmt, dif.wr_rd); else passes++;
        send_dut(32'h0FF0808F, 32'h118);
        checks++; if (dif.fmt !== FMT_I || dif.use_rs1 !== 1'b0 || dif.wr_rd !== 1'b0 || dif.illegal !== 1'b0)
            $display("FAIL fence: got fmt %0d r1 %b wr %b ill %b expected 1 0 0 0", dif.fmt, dif.use_rs1, dif.wr_rd, dif.illegal); else passes++;
    endtask

    task automatic test_mul();
        send_dut(32'h022081B3, 32'h120);
        checks++; if (dif.is_mul !== 1'b1 || dif.illegal !== 1'b0 || dif.wr_rd !== 1'b1 || dif.rd !== 5'd3)
            $display("FAIL mul_en: got mul %b ill %b wr %b rd %0d expected 1 0 1 3", dif.is_mul, dif.illegal, dif.wr_rd, dif.rd); else passes++;
        checks++; if (dif.fmt !== FMT_R || dif.imm !== 32'h0) $display("FAIL mul_rtype: got fmt %0d imm %h expected 0 00000000", dif.fmt, dif.imm); else passes++;
        send_nm(32'h022081B3, 32'h120);
        checks++; if (dnm.illegal !== 1'b1 || dnm.wr_rd !== 1'b0 || dnm.is_mul !== 1'b0 || dnm.fmt !== FMT_NONE)
            $display("FAIL mul_dis: got ill %b wr %b mul %b fmt %0d expected 1 0 0 6", dnm.illegal, dnm.wr_rd, dnm.is_mul, dnm.fmt); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[$];
        int          idx;
        logic        fired;
        @(negedge clock);
        dif.out_ready = 1'b0; dif.in_valid = 1'b1; dif.in_instr = 32'h00100093; dif.in_pc = 32'h0;
        idx = 0;
        @(negedge clock);
        checks++; if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'h0 || dif.in_ready !== 1'b1)
            $display("FAIL bp_first: got v %b pc %h rdy %b expected 1 00000000 1", dif.out_valid, dif.out_pc, dif.in_ready); else passes++;
        idx = 1; dif.in_pc = 32'h4;
        @(negedge clock);
        checks++; if (dif.in_ready !== 1'b0) $display("FAIL bp_ready_drop: got %b expected 0", dif.in_ready); else passes++;
        idx = 2; dif.in_pc = 32'h8;
        @(negedge clock);
        checks++; if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'h0 || dif.in_ready !== 1'b0)
            $display("FAIL bp_stable: got v %b pc %h rdy %b expected 1 00000000 0", dif.out_valid, dif.out_pc, dif.in_ready); else passes++;
        dif.out_ready = 1'b1;
        fired = 1'b0;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            if (fired) begin
                idx++;
                if (idx < 4) dif.in_pc = 32'(idx * 4);
                else dif.in_valid = 1'b0;
            end
            fired = dif.in_valid && dif.in_ready;
            if (dif.out_valid) got.push_back(dif.out_pc);
            @(negedge clock);
        end
        checks++; if (got.size() != 4) $display("FAIL bp_count: got %0d expected 4", got.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                checks++; if (got[i] !== 32'(i * 4)) $display("FAIL bp_order[%0d]: got %h expected %h", i, got[i], 32'(i * 4)); else passes++;
            end
        end
        dif.in_valid = 1'b0;
        checks++; if (dif.out_valid !== 1'b0) $display("FAIL bp_no_dup: got out_valid %b expected 0", dif.out_valid); else passes++;
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clock);
        dif.out_ready = 1'b0; dif.in_valid = 1'b1; dif.in_instr = 32'h00100093; dif.in_pc = 32'h40;
        @(negedge clock);
        dif.in_pc = 32'h44;
        @(negedge clock);
        checks++; if (dif.in_ready !== 1'b0 || dif.out_valid !== 1'b1) $display("FAIL fl_full: got rdy %b v %b expected 0 1", dif.in_ready, dif.out_valid); else passes++;
        dif.in_pc = 32'h48; flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        checks++; if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) $display("FAIL fl_two: got v %b rdy %b expected 0 1", dif.out_valid, dif.in_ready); else passes++;
        dif.in_pc = 32'h4C;
        @(negedge clock);
        dif.in_pc = 32'h50; flush = 1'b1;
        @(negedge clock);
        flush = 1'b0; dif.in_valid = 1'b0; dif.out_ready = 1'b1;
        checks++; if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) $display("FAIL fl_accept_drop: got v %b rdy %b expected 0 1", dif.out_valid, dif.in_ready); else passes++;
        seen = 0;
        repeat (4) begin
            @(negedge clock);
            if (dif.out_valid) seen++;
        end
        checks++; if (seen != 0) $display("FAIL fl_ghost: got %0d stale outputs expected 0", seen); else passes++;
        send_dut(32'h00100093, 32'h54);
        checks++; if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'h54) $display("FAIL fl_resume: got v %b pc %h expected 1 00000054", dif.out_valid, dif.out_pc); else passes++;
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        dif.out_ready = 1'b0; dif.in_valid = 1'b1; dif.in_instr = 32'h00100093; dif.in_pc = 32'h60;
        @(negedge clock);
        dif.in_pc = 32'h64;
        @(negedge clock);
        dif.in_valid = 1'b0;
        checks++; if (dif.out_valid !== 1'b1) $display("FAIL ar_pre: got %b expected 1", dif.out_valid); else passes++;
        #2 n_reset = 1'b0;
        #1;
        checks++; if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b0) $display("FAIL ar_immediate: got v %b rdy %b expected 0 0", dif.out_valid, dif.in_ready); else passes++;
        checks++; if (dif.out_pc !== 32'h0 || dif.fmt !== FMT_NONE) $display("FAIL ar_bundle: got pc %h fmt %0d expected 00000000 6", dif.out_pc, dif.fmt); else passes++;
        @(negedge clock);
        n_reset = 1'b1; dif.out_ready = 1'b1;
        @(negedge clock);
        checks++; if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0) $display("FAIL ar_release: got rdy %b v %b expected 1 0", dif.in_ready, dif.out_valid); else passes++;
    endtask

    task automatic test_illegal();
        send_dut(32'h00000000, 32'h200);
        checks++; if (dif.illegal !== 1'b1 || dif.fmt !== FMT_NONE || dif.imm !== 32'h0)
            $display("FAIL ill_zero: got ill %b fmt %0d imm %h expected 1 6 00000000", dif.illegal, dif.fmt, dif.imm); else passes++;
        send_dut(32'h40001013, 32'h204);
        checks++; if (dif.illegal !== 1'b1 || dif.use_rs1 !== 1'b0) $display("FAIL ill_slli: got ill %b r1 %b expected 1 0", dif.illegal, dif.use_rs1); else passes++;
        send_dut(32'h40105093, 32'h208);
        checks++; if (dif.illegal !== 1'b0 || dif.wr_rd !== 1'b1 || dif.imm !== 32'h00000401)
            $display("FAIL srai_ok: got ill %b wr %b imm %h expected 0 1 00000401", dif.illegal, dif.wr_rd, dif.imm); else passes++;
        send_dut(32'h00003083, 32'h20C);
        checks++; if (dif.illegal !== 1'b1 || dif.wr_rd !== 1'b0) $display("FAIL ill_load: got ill %b wr %b expected 1 0", dif.illegal, dif.wr_rd); else passes++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_imm_formats();
        test_mul();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_illegal();
        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
